pc_gen: RTL and testbench

//   Program-counter generator: the stage directly upstream of the IF stage.

---
 rtl/pc_gen.sv | 96 +++++++++
 tb/tb_pc_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch PC generator with a direct-mapped BTB of 2-bit saturating counters.
// Resolves EX branches against their carried prediction and redirects fetch on a mispredict.
module pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus_1_if,
    input  logic        stall_if,
    output logic        pred_taken_if,
    output logic [31:0] pred_target_if,
    input  logic        ex_br_valid,
    input  logic [31:0] ex_br_pc,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX;

    logic              btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
    logic [31:0]       btb_target [BTB_ENTRIES];
    logic [1:0]        btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             rd_hit;
    logic             wr_hit;
    logic [31:0]      redirect_pc;

    assign rd_idx = pc[IDX+1:2];
    assign rd_tag = pc[31:IDX+2];
    assign wr_idx = ex_br_pc[IDX+1:2];
    assign wr_tag = ex_br_pc[31:IDX+2];

    always_comb begin
        rd_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
        wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
    end

    // Lookup reads the array before this edge's update, so same-index traffic sees old contents.
    always_comb begin
        pred_taken_if  = rd_hit & btb_ctr[rd_idx][1] & ~rst;
        pred_target_if = (rd_hit && !rst) ? btb_target[rd_idx] : pc_plus_1_if;
    end

    always_comb begin
        mispredict  = ~rst & ex_br_valid &
                      ((ex_br_taken != ex_pred_taken) |
                       (ex_br_taken & ex_pred_taken & (ex_br_target != ex_pred_target)));
        redirect_pc = ex_br_taken ? ex_br_target : ex_br_pc + 32'h4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (mispredict) begin
            pc <= redirect_pc;
        end else if (!stall_if) begin
            pc <= pred_taken_if ? pred_target_if : pc_plus_1_if;
        end
    end

    // Tag/target need no reset: a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else if (ex_br_valid) begin
            if (wr_hit) begin
                if (ex_br_taken) begin
                    if (btb_ctr[wr_idx] != 2'b11) btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'd1;
                    btb_target[wr_idx] <= ex_br_target;
                end else if (btb_ctr[wr_idx] != 2'b00) begin
                    btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'd1;
                end
            end else if (ex_br_taken) begin
                btb_valid[wr_idx]  <= 1'b1;
                btb_tag[wr_idx]    <= wr_tag;
                btb_target[wr_idx] <= ex_br_target;
                btb_ctr[wr_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios then randomized traffic,
// checked against an arithmetic model of the PC/BTB rules.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h100;
    localparam int unsigned BTB_N  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_plus_1_if;
    logic        stall_if;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;
    logic        ex_br_valid;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;

    pc_gen #(.RESET_PC(RST_PC), .BTB_ENTRIES(BTB_N)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_plus_1_if(pc_plus_1_if), .stall_if(stall_if),
        .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken),
        .ex_br_target(ex_br_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        int unsigned tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    typedef struct {
        bit          pc_known;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        mis;
    } exp_t;

    ent_t        mb [BTB_N];
    logic [31:0] m_pc    = 32'h0;
    bit          m_known = 1'b0;
    exp_t        sb [$];
    int          checks   = 0;
    int          failures = 0;

    logic [31:0] br_pcs  [8] = '{32'h104, 32'h108, 32'h144, 32'h100, 32'h180, 32'h1C4, 32'h10C, 32'h204};
    logic [31:0] br_tgts [8] = '{32'h100, 32'h104, 32'h140, 32'h144, 32'h180, 32'h200, 32'h108, 32'h1C0};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void look(input logic [31:0] a, output bit hit, output bit taken,
                                 output logic [31:0] tgt);
        int unsigned i;
        i     = (a >> 2) % BTB_N;
        hit   = mb[i].v && (mb[i].tag == (a >> 2) / BTB_N);
        taken = hit && (mb[i].ctr >= 2);
        tgt   = mb[i].tgt;
    endfunction

    // One cycle of stimulus; expected outputs for this cycle go to the scoreboard.
    task automatic step(input bit r, input bit st, input bit bv, input logic [31:0] bpc,
                        input bit bt, input logic [31:0] btgt, input bit pt, input logic [31:0] ptgt);
        exp_t        e;
        bit          h, t;
        logic [31:0] tg;
        int unsigned i;
        @(posedge clk);
        #1;
        rst = r; stall_if = st; ex_br_valid = bv; ex_br_pc = bpc; ex_br_taken = bt;
        ex_br_target = btgt; ex_pred_taken = pt; ex_pred_target = ptgt;
        pc_plus_1_if = m_pc + 32'd4;
        look(m_pc, h, t, tg);
        e.pc_known = m_known;
        e.pc       = m_pc;
        if (r) begin
            e.pt = 1'b0; e.ptgt = m_pc + 32'd4; e.mis = 1'b0;
        end else begin
            e.pt   = t;
            e.ptgt = h ? tg : m_pc + 32'd4;
            e.mis  = bv && ((bt != pt) || (bt && pt && (btgt != ptgt)));
        end
        sb.push_back(e);
        if (r) begin
            m_pc = RST_PC; m_known = 1'b1;
            for (int k = 0; k < BTB_N; k++) begin mb[k].v = 1'b0; mb[k].ctr = 1; end
        end else begin
            if (e.mis)     m_pc = bt ? btgt : bpc + 32'd4;
            else if (!st)  m_pc = e.pt ? e.ptgt : m_pc + 32'd4;
            if (bv) begin
                i = (bpc >> 2) % BTB_N;
                if (mb[i].v && mb[i].tag == (bpc >> 2) / BTB_N) begin
                    if (bt) begin
                        if (mb[i].ctr < 3) mb[i].ctr++;
                        mb[i].tgt = btgt;
                    end else if (mb[i].ctr > 0) begin
                        mb[i].ctr--;
                    end
                end else if (bt) begin
                    mb[i].v = 1'b1; mb[i].tag = (bpc >> 2) / BTB_N; mb[i].tgt = btgt; mb[i].ctr = 2;
                end
            end
        end
    endtask

    task automatic idle(input bit st);
        step(1'b0, st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic pc_is(input string name, input logic [31:0] exp);
        @(negedge clk);
        chk(name, pc, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.pc_known) chk("sb_pc", pc, e.pc);
                chk("sb_pred_taken", 32'(pred_taken_if), 32'(e.pt));
                chk("sb_pred_target", pred_target_if, e.ptgt);
                chk("sb_mispredict", 32'(mispredict), 32'(e.mis));
            end
        end
    end

    initial begin : stimulus
        bit          h, t;
        logic [31:0] tg, bpc, btgt, ptgt;
        bit          bt, pt;
        rst = 1'b1; stall_if = 1'b0; ex_br_valid = 1'b0; ex_br_pc = '0; ex_br_taken = 1'b0;
        ex_br_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0; pc_plus_1_if = 32'd4;

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0); pc_is("reset_pc", 32'h100);
        chk("reset_pred_taken", 32'(pred_taken_if), 32'h0);
        idle(1'b0); pc_is("seq_104", 32'h104);
        idle(1'b1); pc_is("stall_0", 32'h108);
        idle(1'b1); pc_is("stall_1", 32'h108);
        idle(1'b1); pc_is("stall_2", 32'h108);
        idle(1'b0); pc_is("stall_end", 32'h108);
        idle(1'b0); pc_is("resume_10c", 32'h10C);

        // Taken branch at 0x104 that was predicted not-taken.
        step(1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h0);
        @(negedge clk); chk("br_taken_mis", 32'(mispredict), 32'h1);
        idle(1'b0); pc_is("redirect_200", 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h104, 1'b0, 32'h0);
        idle(1'b0); pc_is("at_104", 32'h104);
        chk("btb_pred_taken", 32'(pred_taken_if), 32'h1);
        chk("btb_pred_target", pred_target_if, 32'h200);
        idle(1'b0); pc_is("follow_pred_200", 32'h200);

        // Two not-taken resolves walk the counter down to 00.
        step(1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h200);
        @(negedge clk); chk("nt_second_mis", 32'(mispredict), 32'h1);
        idle(1'b0); pc_is("redirect_108", 32'h108);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h104, 1'b0, 32'h0);
        idle(1'b0); pc_is("back_104", 32'h104);
        chk("nt_pred_taken", 32'(pred_taken_if), 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk); chk("nt_correct_nomis", 32'(mispredict), 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h104, 1'b0, 32'h0);
        idle(1'b0); pc_is("sat_104", 32'h104);
        chk("sat_low_pred", 32'(pred_taken_if), 32'h0);

        // Mispredict beats stall; reset beats mispredict.
        step(1'b0, 1'b1, 1'b1, 32'h120, 1'b1, 32'h180, 1'b0, 32'h0);
        idle(1'b0); pc_is("mis_over_stall", 32'h180);
        step(1'b1, 1'b1, 1'b1, 32'h120, 1'b1, 32'h180, 1'b0, 32'h0);
        @(negedge clk); chk("rst_mis_low", 32'(mispredict), 32'h0);
        idle(1'b0); pc_is("rst_over_mis", 32'h100);

        // Same index, different tag must miss.
        step(1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h3F0, 1'b1, 32'h144, 1'b0, 32'h0);
        idle(1'b0); pc_is("alias_144", 32'h144);
        chk("alias_pred_taken", 32'(pred_taken_if), 32'h0);
        chk("alias_pred_target", pred_target_if, 32'h148);

        for (int n = 0; n < 3000; n++) begin
            bpc  = br_pcs[$urandom_range(7)];
            btgt = br_tgts[$urandom_range(7)];
            bt   = 1'($urandom_range(1));
            if ($urandom_range(1) == 1) begin
                look(bpc, h, t, tg);
                pt   = t;
                ptgt = h ? tg : bpc + 32'd4;
            end else begin
                pt   = 1'($urandom_range(1));
                ptgt = br_tgts[$urandom_range(7)];
            end
            step(($urandom_range(99) == 0), ($urandom_range(4) == 0), ($urandom_range(2) == 0),
                 bpc, bt, btgt, pt, ptgt);
        end

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        #1;
        if (sb.size() > 0) chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
